// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, fetch state encoding and opcode helper
package cpu_pkg;

   localparam int ADDR_W  = 16;
   localparam int INSTR_W = 16;

   // Opcode field of every instruction word
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;

   localparam logic [3:0]         HALT_OPCODE = 4'hF;
   localparam logic [INSTR_W-1:0] NOP_INSTR   = 16'h0000;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_e;

   function automatic logic is_halt(input logic [INSTR_W-1:0] instr,
                                    input logic [3:0]         halt_opc);
      return instr[OPC_MSB:OPC_LSB] == halt_opc;
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with load, hold and bubble controls
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load_i          capture instr_i / pc_plus1_i as a valid instruction
//   bubble_i        insert NOP_INSTR with valid cleared (wins over load_i)
//   instr_i         fetched instruction word
//   pc_plus1_i      address of the fetched word plus one
//   instr_o         IF/ID instruction
//   pc_plus1_o      IF/ID PC+1
//   valid_o         IF/ID holds a real instruction
// With neither load_i nor bubble_i the register holds.
module ifid_reg
   import cpu_pkg::*;
#(
   parameter logic [INSTR_W-1:0] NOP_VALUE = NOP_INSTR
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic               bubble_i,
   input  logic [INSTR_W-1:0] instr_i,
   input  logic [ADDR_W-1:0]  pc_plus1_i,
   output logic [INSTR_W-1:0] instr_o,
   output logic [ADDR_W-1:0]  pc_plus1_o,
   output logic               valid_o
);

   logic [INSTR_W-1:0] instr_q,    instr_d;
   logic [ADDR_W-1:0]  pc_plus1_q, pc_plus1_d;
   logic               valid_q,    valid_d;

   always_comb begin
      instr_d    = instr_q;
      pc_plus1_d = pc_plus1_q;
      valid_d    = valid_q;
      if (bubble_i) begin
         instr_d = NOP_VALUE;
         valid_d = 1'b0;
      end else if (load_i) begin
         instr_d    = instr_i;
         pc_plus1_d = pc_plus1_i;
         valid_d    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q    <= NOP_VALUE;
         pc_plus1_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         instr_q    <= instr_d;
         pc_plus1_q <= pc_plus1_d;
         valid_q    <= valid_d;
      end
   end

   assign instr_o    = instr_q;
   assign pc_plus1_o = pc_plus1_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC, instruction memory request, IF/ID capture, halt detect
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stall             hold PC and IF/ID
//   branch_taken      redirect to branch_target and flush IF/ID (wins over stall)
//   branch_target     word address to redirect to
//   im_instr          instruction word for im_addr, valid before the rising edge
//   im_addr           current PC
//   im_rd_en          instruction memory read enable
//   ifid_instr        IF/ID instruction
//   ifid_pc_plus1     IF/ID PC+1
//   ifid_valid        IF/ID holds a real instruction
//   halted            fetch stopped on a halt instruction
module fetch_unit
#(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [3:0]  HALT_OPCODE = cpu_pkg::HALT_OPCODE,
   parameter logic [15:0] NOP_INSTR   = cpu_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   input  logic [15:0] im_instr,
   output logic [15:0] im_addr,
   output logic        im_rd_en,
   output logic [15:0] ifid_instr,
   output logic [15:0] ifid_pc_plus1,
   output logic        ifid_valid,
   output logic        halted
);

   import cpu_pkg::*;

   fetch_state_e       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  pc_plus1;
   logic               ifid_load;
   logic               ifid_bubble;

   // Word addressed; the 16-bit add wraps FFFF -> 0000 naturally
   assign pc_plus1 = pc_q + 16'd1;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;
      unique case (state_q)
         RUN: begin
            if (branch_taken) begin
               // The word fetched this cycle is on the wrong path: drop it,
               // even when it is a halt.
               pc_d        = branch_target;
               ifid_bubble = 1'b1;
            end else if (!stall) begin
               ifid_load = 1'b1;
               if (is_halt(im_instr, HALT_OPCODE)) begin
                  state_d = HALTED;
               end else begin
                  pc_d = pc_plus1;
               end
            end
         end
         HALTED: begin
            if (branch_taken) begin
               // An older branch resolving now squashes the speculative halt
               pc_d        = branch_target;
               ifid_bubble = 1'b1;
               state_d     = RUN;
            end else if (!stall) begin
               // Halt has moved on to ID; keep feeding bubbles behind it
               ifid_bubble = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   ifid_reg #(
      .NOP_VALUE (NOP_INSTR)
   ) u_ifid_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (ifid_load),
      .bubble_i   (ifid_bubble),
      .instr_i    (im_instr),
      .pc_plus1_i (pc_plus1),
      .instr_o    (ifid_instr),
      .pc_plus1_o (ifid_pc_plus1),
      .valid_o    (ifid_valid)
   );

   assign im_addr  = pc_q;
   // Gated by rst_n directly so the read stops the moment reset asserts
   assign im_rd_en = rst_n & (state_q == RUN) & ~stall;
   assign halted   = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [15:0] branch_target = 16'h0000;
   logic [15:0] im_instr;
   logic [15:0] im_addr;
   logic        im_rd_en;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_pc_plus1;
   logic        ifid_valid;
   logic        halted;

   logic [15:0] mem [0:65535];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .im_instr      (im_instr),
      .im_addr       (im_addr),
      .im_rd_en      (im_rd_en),
      .ifid_instr    (ifid_instr),
      .ifid_pc_plus1 (ifid_pc_plus1),
      .ifid_valid    (ifid_valid),
      .halted        (halted)
   );

   assign im_instr = mem[im_addr];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: fetch stage as a program counter plus a one-slot
   // IF/ID buffer, advanced once per edge by the stage rules.
   logic [15:0] m_pc, m_instr, m_pp1;
   logic        m_valid, m_halt;

   always @(posedge clk or negedge rst_n) begin
      logic [15:0] w;
      if (!rst_n) begin
         m_pc = 16'h0000; m_instr = 16'h0000; m_pp1 = 16'h0000;
         m_valid = 1'b0;  m_halt = 1'b0;
      end else begin
         w = mem[m_pc];
         if (branch_taken) begin
            m_pc = branch_target; m_instr = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
         end else if (stall) begin
            // everything holds
         end else if (m_halt) begin
            m_instr = 16'h0000; m_valid = 1'b0;
         end else begin
            m_instr = w; m_pp1 = m_pc + 16'd1; m_valid = 1'b1;
            if (w[15:12] == 4'hF) m_halt = 1'b1;
            else m_pc = m_pc + 16'd1;
         end
      end
   end

   always @(negedge clk) begin
      check("cyc_im_addr",  im_addr,       m_pc);
      check("cyc_rd_en",    {15'd0, im_rd_en}, {15'd0, rst_n & ~m_halt & ~stall});
      check("cyc_instr",    ifid_instr,    m_instr);
      check("cyc_pc_plus1", ifid_pc_plus1, m_pp1);
      check("cyc_valid",    {15'd0, ifid_valid}, {15'd0, m_valid});
      check("cyc_halted",   {15'd0, halted},     {15'd0, m_halt});
   end

   // Drive inputs for the next edge, then sample just after the following negedge
   task automatic step(input logic s, input logic b, input logic [15:0] t);
      stall = s; branch_taken = b; branch_target = t;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'h5000 | (i[15:0] & 16'h0FFF);
      mem[0] = 16'h1001; mem[1] = 16'h2002; mem[2] = 16'h3003; mem[7] = 16'hF000;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_im_addr", im_addr, 16'h0000);
      check("rst_rd_en",   {15'd0, im_rd_en}, 16'h0000);
      check("rst_valid",   {15'd0, ifid_valid}, 16'h0000);
      check("rst_instr",   ifid_instr, 16'h0000);
      check("rst_halted",  {15'd0, halted}, 16'h0000);
      rst_n = 1'b1;
      #1;
      check("run_rd_en", {15'd0, im_rd_en}, 16'h0001);

      // Free run
      step(0, 0, 0);
      check("fr1_addr", im_addr, 16'h0001);
      check("fr1_instr", ifid_instr, 16'h1001);
      check("fr1_pp1", ifid_pc_plus1, 16'h0001);
      check("fr1_valid", {15'd0, ifid_valid}, 16'h0001);
      step(0, 0, 0);
      check("fr2_addr", im_addr, 16'h0002);
      check("fr2_instr", ifid_instr, 16'h2002);
      check("fr2_pp1", ifid_pc_plus1, 16'h0002);

      // Stall two cycles at pc=2
      step(1, 0, 0);
      check("st1_addr", im_addr, 16'h0002);
      check("st1_rd_en", {15'd0, im_rd_en}, 16'h0000);
      check("st1_instr", ifid_instr, 16'h2002);
      step(1, 0, 0);
      check("st2_addr", im_addr, 16'h0002);
      check("st2_valid", {15'd0, ifid_valid}, 16'h0001);
      step(0, 0, 0);
      check("fr3_addr", im_addr, 16'h0003);
      check("fr3_instr", ifid_instr, 16'h3003);
      check("fr3_pp1", ifid_pc_plus1, 16'h0003);
      step(0, 0, 0);
      step(0, 0, 0);
      check("pc5", im_addr, 16'h0005);

      // Branch with simultaneous stall
      step(1, 1, 16'h0040);
      check("br_addr", im_addr, 16'h0040);
      check("br_valid", {15'd0, ifid_valid}, 16'h0000);
      check("br_instr", ifid_instr, 16'h0000);
      step(0, 0, 0);
      check("br_next_instr", ifid_instr, 16'h5040);
      check("br_next_pp1", ifid_pc_plus1, 16'h0041);

      // Halt at pc=7
      step(0, 1, 16'h0007);
      step(0, 0, 0);
      check("h_instr", ifid_instr, 16'hF000);
      check("h_valid", {15'd0, ifid_valid}, 16'h0001);
      check("h_halted", {15'd0, halted}, 16'h0001);
      check("h_rd_en", {15'd0, im_rd_en}, 16'h0000);
      check("h_addr", im_addr, 16'h0007);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0);
         check("h_bubble_valid", {15'd0, ifid_valid}, 16'h0000);
         check("h_hold_addr", im_addr, 16'h0007);
      end

      // Squash (b): branch one cycle after entering HALTED
      step(0, 1, 16'h0007);
      step(0, 0, 0);
      check("sqb_entered", {15'd0, halted}, 16'h0001);
      step(0, 1, 16'h0010);
      check("sqb_addr", im_addr, 16'h0010);
      check("sqb_valid", {15'd0, ifid_valid}, 16'h0000);
      check("sqb_halted", {15'd0, halted}, 16'h0000);

      // Squash (a): branch in the same cycle the halt word is fetched
      step(0, 1, 16'h0007);
      step(0, 1, 16'h0010);
      check("sqa_addr", im_addr, 16'h0010);
      check("sqa_valid", {15'd0, ifid_valid}, 16'h0000);
      check("sqa_halted", {15'd0, halted}, 16'h0000);

      // PC wrap
      step(0, 1, 16'hFFFF);
      step(0, 0, 0);
      check("wrap_addr", im_addr, 16'h0000);
      check("wrap_pp1", ifid_pc_plus1, 16'h0000);
      check("wrap_instr", ifid_instr, 16'h5FFF);
      step(0, 0, 0);

      // Asynchronous reset during the clk-high phase
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_addr", im_addr, 16'h0000);
      check("ar_rd_en", {15'd0, im_rd_en}, 16'h0000);
      check("ar_valid", {15'd0, ifid_valid}, 16'h0000);
      check("ar_instr", ifid_instr, 16'h0000);
      check("ar_pp1", ifid_pc_plus1, 16'h0000);
      check("ar_halted", {15'd0, halted}, 16'h0000);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      step(0, 0, 0);
      check("post_rst_addr", im_addr, 16'h0001);
      check("post_rst_instr", ifid_instr, 16'h1001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage of the 5-stage pipelined CPU.
- Owns the PC and drives the instruction memory's addr/rd_en.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles stall, branch redirect/flush and halt detection; feeds the decode stage.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_OPCODE, 4'hF, instr[15:12] value that marks a halt instruction.
- NOP_INSTR, 16'h0000, instruction value inserted into IF/ID for a bubble.

Ports:
- clk  input  1  system clock; instruction memory output is valid by the end of the clk-low phase.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hazard unit: hold PC and IF/ID.
- branch_taken  input  1  branch/jump resolved taken this cycle: redirect and flush.
- branch_target  input  16  word address to redirect to.
- im_instr  input  16  instruction word from instruction memory.
- im_addr  output  16  current PC to instruction memory.
- im_rd_en  output  1  read enable to instruction memory.
- ifid_instr  output  16  IF/ID instruction.
- ifid_pc_plus1  output  16  IF/ID PC+1 (link/branch base).
- ifid_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  fetch stopped on a halt instruction.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- While rst_n is low:
  - pc = RESET_PC; state = RUN.
  - ifid_instr = NOP_INSTR; ifid_pc_plus1 = 16'h0000; ifid_valid = 0.
  - halted = 0; im_rd_en = 0 (gated combinationally).
- Addressing: word addressed; pc+1 wraps 16'hFFFF -> 16'h0000. im_addr = pc, combinational from the register.
- im_rd_en = rst_n & (state==RUN) & ~stall.
- Latency: pc presented in cycle N; im_instr is sampled at the rising edge that ends cycle N; it appears on ifid_* in cycle N+1.
- FSM states are RUN and HALTED.
- RUN, per rising edge, in priority order:
  1. branch_taken: pc <= branch_target; IF/ID <= bubble (NOP_INSTR, valid=0). Overrides stall. The fetched word is discarded, even if it is a halt.
  2. stall: pc, IF/ID and state hold.
  3. im_instr[15:12]==HALT_OPCODE: IF/ID <= {im_instr, pc+1, valid=1}; pc holds; state <= HALTED.
  4. otherwise: IF/ID <= {im_instr, pc+1, valid=1}; pc <= pc+1.
- HALTED:
  - halted = 1 (registered: state==HALTED); im_rd_en = 0; pc holds.
  - The IF/ID register is loaded with a bubble each edge unless stall is high, in which case it holds. The halt instruction therefore advances to ID exactly once.
  - branch_taken: pc <= branch_target; IF/ID <= bubble; state <= RUN. This squashes a speculatively fetched halt.
  - Otherwise HALTED is left only by reset.
- Simultaneous stall and branch_taken: branch wins.
- Reset mid-operation: all state returns to reset values immediately; no partial IF/ID update.

Decomposition:
- Shared package cpu_pkg:
  - HALT_OPCODE and NOP_INSTR constants, plus opcode field position [15:12].
  - Fetch state encoding (RUN=1'b0, HALTED=1'b1).
  - 16-bit address/instruction width constants.
- One natural sub-module: ifid_reg, the IF/ID pipeline register with load/hold/bubble controls.
- PC logic and FSM stay in fetch_unit.

Test Plan:
- Reset then free-run; memory holds 16'h1001, 16'h2002, 16'h3003 at 0..2 -> im_addr 0,1,2,3 on successive cycles; ifid_instr 1001, 2002, 3003 with ifid_pc_plus1 1, 2, 3 and ifid_valid=1, starting one cycle after each address.
- Stall for 2 cycles while pc=2 -> im_addr stays 2 and im_rd_en=0 during stall; ifid holds 2002/valid=1; after release, 3003 is captured and im_addr goes to 3.
- Branch: branch_taken=1, target 16'h0040 while pc=5; stall=1 in the same cycle -> next cycle im_addr=0x0040, ifid_valid=0, ifid_instr=NOP_INSTR; the following cycle ifid_instr holds the word at 0x0040.
- Halt: word F000 at pc=7 -> ifid_instr=F000, valid=1 once; halted=1 and im_rd_en=0; im_addr stays 7; subsequent ifid_valid=0 for 10 cycles.
- Speculative halt squash, two cases -> im_addr=0x0010, ifid_valid=0, halted=0 in both:
  - (a) branch_taken to 0x0010 in the same cycle F000 is fetched.
  - (b) branch_taken to 0x0010 one cycle after entering HALTED.
- Wrap and async reset:
  - Start at pc=16'hFFFF -> next im_addr=0x0000 and ifid_pc_plus1=0x0000.
  - Assert rst_n low mid-cycle -> outputs reach reset values without waiting for clk.
